// File: rtl/player_proj_scheduler.sv
// player_proj_scheduler: fixed pool of player projectile slots.
//   clk_master, rst_n (async active-low)
//   pulse_stepCycle : game-step strobe; fire/cooldown/movement act on it
//   fire            : level fire request
//   playerX         : player left edge
//   gameOver        : flushes all slots, blocks fire
//   projHit         : per-slot collision strobe
//   projActive/projX/projY : slot state (X/Y valid only while active)
//   shotFired       : strobe on an accepted shot
//   cooldownBusy    : cooldown counter nonzero
module player_proj_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int PROJ_STEP    = 10,
  parameter int TOP_BOUNDARY = 35,
  parameter int COOLDOWN     = 8,
  parameter int PLAYER_Y     = 450,
  parameter int PLAYER_W     = 30,
  parameter int PROJ_W       = 10,
  parameter int PROJ_H       = 10
) (
  input  logic                   clk_master,
  input  logic                   rst_n,
  input  logic                   pulse_stepCycle,
  input  logic                   fire,
  input  logic [9:0]             playerX,
  input  logic                   gameOver,
  input  logic [NUM_SLOTS-1:0]   projHit,
  output logic [NUM_SLOTS-1:0]   projActive,
  output logic [10*NUM_SLOTS-1:0] projX,
  output logic [9*NUM_SLOTS-1:0] projY,
  output logic                   shotFired,
  output logic                   cooldownBusy
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [9:0]    X_OFF   = 10'((PLAYER_W - PROJ_W) / 2);
  localparam logic [8:0]    Y_SPAWN = 9'(PLAYER_Y - PROJ_H);
  localparam logic [8:0]    Y_LIMIT = 9'(TOP_BOUNDARY + PROJ_STEP);
  localparam logic [8:0]    Y_STEP  = 9'(PROJ_STEP);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

  logic [CW-1:0]        cooldown;
  logic [CW-1:0]        cooldown_nxt;
  logic                 accept;
  logic                 found;
  logic [NUM_SLOTS-1:0] alloc;

  // Lowest-index free slot, taken from the pre-update active bits so a slot
  // freed by the boundary check this pulse is not reused until the next one.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!projActive[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    accept = pulse_stepCycle && fire && !gameOver && (cooldown == '0) && found;
    cooldown_nxt = cooldown;
    if (pulse_stepCycle) begin
      if (accept)
        cooldown_nxt = CD_LOAD;
      else if (cooldown != '0)
        cooldown_nxt = cooldown - CW'(1);
    end
  end

  always_ff @(posedge clk_master or negedge rst_n) begin
    if (!rst_n) begin
      projActive   <= '0;
      projX        <= '0;
      projY        <= '0;
      shotFired    <= 1'b0;
      cooldownBusy <= 1'b0;
      cooldown     <= '0;
    end else begin
      shotFired    <= accept;
      cooldown     <= cooldown_nxt;
      cooldownBusy <= (cooldown_nxt != '0);
      // Priority per slot: gameOver > new spawn > hit > movement.
      // Boundary test precedes the subtraction so Y never wraps.
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (gameOver) begin
          projActive[i] <= 1'b0;
        end else if (accept && alloc[i]) begin
          projActive[i]     <= 1'b1;
          projX[10*i +: 10] <= playerX + X_OFF;
          projY[9*i +: 9]   <= Y_SPAWN;
        end else if (projHit[i]) begin
          projActive[i] <= 1'b0;
        end else if (pulse_stepCycle && projActive[i]) begin
          if (projY[9*i +: 9] < Y_LIMIT)
            projActive[i] <= 1'b0;
          else
            projY[9*i +: 9] <= projY[9*i +: 9] - Y_STEP;
        end
      end
    end
  end

endmodule
